// File: rtl/serial_tx_controller_pkg.sv
// Shared types for the serial transmit path: the IO unit's byte type and the
// transmitter's state, sizing constants and drop-counter type.
package IO_UnitTypes;
    typedef logic [7:0] SerialDataPath;
endpackage

package SerialTypes;
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } SerialTxState;

    localparam int SERIAL_TX_FIFO_DEPTH = 16;
    localparam int SERIAL_BAUD_DIVISOR  = 542;

    typedef logic [15:0] SerialDropCountPath;
endpackage

// File: rtl/serial_tx_controller_if.sv
// Byte-write handshake between the IO unit (master) and the serial transmitter (slave).
interface serial_tx_controller_if;
    import IO_UnitTypes::*;

    logic          serialWE;
    SerialDataPath serialWriteData;
    logic          serialReady;

    modport master (output serialWE, output serialWriteData, input serialReady);
    modport slave  (input serialWE, input serialWriteData, output serialReady);
endinterface

// File: rtl/serial_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head data is read combinationally.
module serial_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             negResetIn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] headData
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      headPtr;
    logic [AW:0]      tailPtr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty    = (headPtr == tailPtr);
    assign full     = (headPtr[AW-1:0] == tailPtr[AW-1:0]) && (headPtr[AW] != tailPtr[AW]);
    assign headData = mem[headPtr[AW-1:0]];

    // Reset only clears the pointers, which discards whatever the storage holds.
    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            headPtr <= '0;
            tailPtr <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + 1'b1;
            if (pop)  headPtr <= headPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tailPtr[AW-1:0]] <= pushData;
    end
endmodule

// File: rtl/serial_tx_controller.sv
// Buffers IO-unit byte writes and sends them on txd as 8N1 frames, counting
// bytes lost when the core writes faster than the line drains.
module serial_tx_controller
    import IO_UnitTypes::*;
    import SerialTypes::*;
#(
    parameter int FIFO_DEPTH   = SERIAL_TX_FIFO_DEPTH,
    parameter int BAUD_DIVISOR = SERIAL_BAUD_DIVISOR
) (
    input  logic                   clk,
    input  logic                   negResetIn,
    serial_tx_controller_if.slave  io,
    output logic                   txd,
    output logic                   busy,
    output logic                   overflow,
    output SerialDropCountPath     dropCount
);
    localparam int CW = $clog2(BAUD_DIVISOR);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIVISOR - 1);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gBadFifoDepth
        $error("serial_tx_controller: FIFO_DEPTH must be a power of two >= 2");
    end
    if (BAUD_DIVISOR < 2) begin : gBadBaudDivisor
        $error("serial_tx_controller: BAUD_DIVISOR must be >= 2");
    end

    SerialTxState  state, stateNext;
    logic [CW-1:0] baudCount, baudCountNext;
    SerialDataPath shiftReg, shiftNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic          txdNext;
    logic          fifoFull, fifoEmpty, fifoPush, fifoPop, dropEvent;
    SerialDataPath fifoHead;

    serial_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(SerialDataPath))) txFifo (
        .clk        (clk),
        .negResetIn (negResetIn),
        .push       (fifoPush),
        .pop        (fifoPop),
        .pushData   (io.serialWriteData),
        .full       (fifoFull),
        .empty      (fifoEmpty),
        .headData   (fifoHead)
    );

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign fifoPush       = io.serialWE && (!fifoFull || fifoPop);
    assign dropEvent      = io.serialWE && fifoFull && !fifoPop;
    assign io.serialReady = !fifoFull;
    assign busy           = (state != IDLE) || !fifoEmpty;

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            state     <= IDLE;
            baudCount <= '0;
            shiftReg  <= '0;
            bitIdx    <= '0;
            txd       <= 1'b1;
        end else begin
            state     <= stateNext;
            baudCount <= baudCountNext;
            shiftReg  <= shiftNext;
            bitIdx    <= bitIdxNext;
            txd       <= txdNext;
        end
    end

    // txd is registered from the next state so the line level changes on the
    // same edge as the state, giving exact BAUD_DIVISOR-cycle bits.
    always_comb begin
        stateNext     = state;
        baudCountNext = baudCount;
        shiftNext     = shiftReg;
        bitIdxNext    = bitIdx;
        fifoPop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop       = 1'b1;
                    shiftNext     = fifoHead;
                    baudCountNext = BAUD_LOAD;
                    stateNext     = START;
                end
            end
            START: begin
                if (baudCount == '0) begin
                    baudCountNext = BAUD_LOAD;
                    bitIdxNext    = '0;
                    stateNext     = DATA;
                end else begin
                    baudCountNext = baudCount - 1'b1;
                end
            end
            DATA: begin
                if (baudCount == '0) begin
                    shiftNext     = {1'b0, shiftReg[7:1]};
                    baudCountNext = BAUD_LOAD;
                    if (bitIdx == 3'd7) stateNext = STOP;
                    else                bitIdxNext = bitIdx + 3'd1;
                end else begin
                    baudCountNext = baudCount - 1'b1;
                end
            end
            STOP: begin
                if (baudCount == '0) begin
                    if (!fifoEmpty) begin
                        fifoPop       = 1'b1;
                        shiftNext     = fifoHead;
                        baudCountNext = BAUD_LOAD;
                        stateNext     = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    baudCountNext = baudCount - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        txdNext = (stateNext == DATA) ? shiftNext[0] : (stateNext != START);
    end

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            overflow  <= 1'b0;
            dropCount <= '0;
        end else if (dropEvent) begin
            overflow <= 1'b1;
            if (dropCount != 16'hFFFF) dropCount <= dropCount + 1'b1;
        end
    end
endmodule
